// File: rtl/ex_mem_if.sv
// EX/MEM pipeline register bus: EX-side inputs, hazard controls and registered MEM-side outputs.
// The master modport belongs to the upstream EX stage. The slave modport is the EX/MEM register itself.
interface ex_mem_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             flush;
  logic             valid_in;
  logic [WIDTH-1:0] alu_in;
  logic [WIDTH-1:0] bbus_in;
  logic [WIDTH-1:0] dsel_in;
  logic             storeValIn;
  logic             loadValIn;
  logic             setValIn;
  logic [1:0]       setValTypeIn;
  logic             z_in;
  logic             n_in;
  logic             v_in;

  logic             valid_out;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] bbus_out;
  logic [WIDTH-1:0] dSelOut;
  logic             storeValOut;
  logic             loadValOut;

  modport master (
    output stall, flush, valid_in, alu_in, bbus_in, dsel_in,
           storeValIn, loadValIn, setValIn, setValTypeIn, z_in, n_in, v_in,
    input  valid_out, dout, bbus_out, dSelOut, storeValOut, loadValOut
  );

  modport slave (
    input  stall, flush, valid_in, alu_in, bbus_in, dsel_in,
           storeValIn, loadValIn, setValIn, setValTypeIn, z_in, n_in, v_in,
    output valid_out, dout, bbus_out, dSelOut, storeValOut, loadValOut
  );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with set-instruction resolution, stall/flush and valid tracking.
// Defining EX_MEM_PERF_EN adds the bubble_cnt and stall_cnt performance counters.
module ex_mem #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  ex_mem_if.slave     bus
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] stall_cnt
`endif
);

  logic             set_cond;
  logic             use_set;
  logic [WIDTH-1:0] dout_next;

  // Set condition from the ALU flags. Loads and stores need the ALU result as an address, so they suppress the set.
  always_comb begin
    set_cond = 1'b0;
    case (bus.setValTypeIn)
      2'b00:   set_cond = bus.n_in ^ bus.v_in;
      2'b01:   set_cond = (bus.n_in ^ bus.v_in) | bus.z_in;
      2'b10:   set_cond = bus.z_in;
      default: set_cond = ~bus.z_in;
    endcase
    use_set   = bus.setValIn & ~bus.storeValIn & ~bus.loadValIn;
    dout_next = use_set ? {{(WIDTH-1){1'b0}}, set_cond} : bus.alu_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out   <= 1'b0;
      bus.dout        <= '0;
      bus.bbus_out    <= '0;
      bus.dSelOut     <= '0;
      bus.storeValOut <= 1'b0;
      bus.loadValOut  <= 1'b0;
    end else if (bus.flush) begin
      bus.valid_out   <= 1'b0;
      bus.dout        <= '0;
      bus.bbus_out    <= '0;
      bus.dSelOut     <= '0;
      bus.storeValOut <= 1'b0;
      bus.loadValOut  <= 1'b0;
    end else if (!bus.stall) begin
      // An invalid slot must never write a register or touch memory.
      bus.valid_out   <= bus.valid_in;
      bus.dout        <= dout_next;
      bus.bbus_out    <= bus.bbus_in;
      bus.dSelOut     <= bus.valid_in ? bus.dsel_in : '0;
      bus.storeValOut <= bus.valid_in & bus.storeValIn;
      bus.loadValOut  <= bus.valid_in & bus.loadValIn;
    end
  end

`ifdef EX_MEM_PERF_EN
  // A bubble is either a flush or a load of an empty EX slot. Both counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (bus.flush || (!bus.stall && !bus.valid_in)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (bus.stall && !bus.flush) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed testbench for ex_mem: reset, ALU pass-through, set resolution, stall/flush and invalid slots.
// The counter checks are compiled only when EX_MEM_PERF_EN is defined.
module tb_ex_mem;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

`ifdef EX_MEM_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] stall_cnt;
`endif

  ex_mem_if #(.WIDTH(WIDTH)) bus ();

  ex_mem #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave)
`ifdef EX_MEM_PERF_EN
    ,
    .bubble_cnt (bubble_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid, input logic [31:0] exp_dout,
                             input logic [31:0] exp_bbus, input logic [31:0] exp_dsel,
                             input logic exp_store, input logic exp_load);
    check32({tag, ".valid_out"},   {31'b0, bus.valid_out},   {31'b0, exp_valid});
    check32({tag, ".dout"},        bus.dout,                 exp_dout);
    check32({tag, ".bbus_out"},    bus.bbus_out,             exp_bbus);
    check32({tag, ".dSelOut"},     bus.dSelOut,              exp_dsel);
    check32({tag, ".storeValOut"}, {31'b0, bus.storeValOut}, {31'b0, exp_store});
    check32({tag, ".loadValOut"},  {31'b0, bus.loadValOut},  {31'b0, exp_load});
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] alu, input logic [31:0] bbus,
                               input logic [31:0] dsel, input logic store, input logic load,
                               input logic set, input logic [1:0] set_type,
                               input logic z, input logic n, input logic v);
    bus.valid_in     = valid;
    bus.alu_in       = alu;
    bus.bbus_in      = bbus;
    bus.dsel_in      = dsel;
    bus.storeValIn   = store;
    bus.loadValIn    = load;
    bus.setValIn     = set;
    bus.setValTypeIn = set_type;
    bus.z_in         = z;
    bus.n_in         = n;
    bus.v_in         = v;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // The first edge after release captures the inputs.
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("first_load", 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle clears the registers without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 32'h00000010, 32'hCAFE0001, 32'h00000008, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("alu_pass", 1'b1, 32'h00000010, 32'hCAFE0001, 32'h00000008, 1'b0, 1'b0);

    applyStimulus(1'b1, 32'h00000055, 32'h1, 32'h00000002, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("slt_n1v0", 1'b1, 32'h1, 32'h1, 32'h00000002, 1'b0, 1'b0);

    applyStimulus(1'b1, 32'h00000055, 32'h2, 32'h00000002, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
    step();
    check32("slt_n1v1.dout", bus.dout, 32'h0);

    applyStimulus(1'b1, 32'h00000055, 32'h3, 32'h00000004, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    step();
    check32("sne_z1.dout", bus.dout, 32'h0);

    applyStimulus(1'b1, 32'h00000055, 32'h4, 32'h00000004, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    step();
    check32("sle_z1.dout", bus.dout, 32'h1);

    applyStimulus(1'b1, 32'h00000055, 32'h5, 32'h00000004, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    check32("sle_gt.dout", bus.dout, 32'h0);

    applyStimulus(1'b1, 32'h00000055, 32'h6, 32'h00000004, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step();
    check32("seq_z1.dout", bus.dout, 32'h1);

    applyStimulus(1'b1, 32'h00000055, 32'h7, 32'h00000004, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    check32("sne_z0.dout", bus.dout, 32'h1);

    // A store or load alongside setValIn keeps the ALU address.
    applyStimulus(1'b1, 32'h00000100, 32'h0000ABCD, 32'h0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("store_set", 1'b1, 32'h00000100, 32'h0000ABCD, 32'h0, 1'b1, 1'b0);

    applyStimulus(1'b1, 32'h00000200, 32'h0, 32'h00000010, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("load_set", 1'b1, 32'h00000200, 32'h0, 32'h00000010, 1'b0, 1'b1);

    // Stall holds the captured instruction while the inputs keep changing.
    applyStimulus(1'b1, 32'h00001234, 32'h00000077, 32'h00000004, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("pre_stall", 1'b1, 32'h00001234, 32'h00000077, 32'h00000004, 1'b1, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hA0 + i, 32'hB0 + i, 32'h00000100, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput($sformatf("stall%0d", i), 1'b1, 32'h00001234, 32'h00000077, 32'h00000004, 1'b1, 1'b0);
    end
    bus.flush = 1'b1;
    step();
    checkOutput("flush_in_stall", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    applyStimulus(1'b0, 32'h0000ABCD, 32'h00000099, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("invalid_in", 1'b0, 32'h0000ABCD, 32'h00000099, 32'h0, 1'b0, 1'b0);

`ifdef EX_MEM_PERF_EN
    rst_n = 1'b0;
    #1;
    check32("perf_reset.bubble", bubble_cnt, 32'h0);
    check32("perf_reset.stall", stall_cnt, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 32'h1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    bus.flush = 1'b1;
    step();
    step();
    bus.flush = 1'b0;
    bus.stall = 1'b1;
    step();
    step();
    step();
    bus.stall = 1'b0;
    bus.valid_in = 1'b0;
    step();
    bus.valid_in = 1'b1;
    check32("perf.bubble_cnt", bubble_cnt, 32'd3);
    check32("perf.stall_cnt", stall_cnt, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
